// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared select encodings and default widths for rr_arb_mux_2to1
package mux_arb_pkg;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/rr_grant_2.sv
// rr_grant_2: combinational two-way round-robin grant favouring the requester that did not win last
module rr_grant_2
  import mux_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);
  always_comb begin
    gnt_idx = (req[1] & (~req[0] | (last == SEL_A))) ? SEL_B : SEL_A;
    gnt     = {req[1] & (gnt_idx == SEL_B), req[0] & (gnt_idx == SEL_A)};
  end
endmodule

// File: rtl/rr_arb_mux_2to1.sv
// rr_arb_mux_2to1: round-robin registered 2:1 handshake mux; ARB_STATS_EN adds saturating per-channel grant counters
module rr_arb_mux_2to1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_sel,
  output logic             out_valid,
`ifdef ARB_STATS_EN
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
`endif
  input  logic             out_ready
);
  logic       last_grant;
  logic       load_en;
  logic [1:0] gnt;
  logic       gnt_idx;
  rr_grant_2 u_grant (
    .req     ({b_valid, a_valid}),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );
  always_comb begin
    load_en = ~rst & (~out_valid | out_ready);
    a_ready = load_en & gnt[0];
    b_ready = load_en & gnt[1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      out_sel    <= SEL_A;
      out_valid  <= 1'b0;
      last_grant <= SEL_B;
    end else if (load_en) begin
      out_valid <= |gnt;
      if (|gnt) begin
        out        <= (gnt_idx == SEL_B) ? b : a;
        out_sel    <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_valid & a_ready & ~&cnt_a) cnt_a <= cnt_a + 1'b1;
      if (b_valid & b_ready & ~&cnt_b) cnt_b <= cnt_b + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_rr_arb_mux_2to1.sv
// tb_rr_arb_mux_2to1: table-driven directed checks plus fairness and optional counter sequences
module tb_rr_arb_mux_2to1;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [3:0] b = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [3:0] out;
  logic       out_sel;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef ARB_STATS_EN
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  rr_arb_mux_2to1 #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b         (b),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out       (out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
`ifdef ARB_STATS_EN
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
`endif
    .out_ready (out_ready)
  );
  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic       av;
    logic [3:0] b;
    logic       bv;
    logic       ory;
    logic       ar;
    logic       br;
    logic [3:0] out;
    logic       sel;
    logic       ov;
  } vec_t;
  vec_t vecs [19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    logic exp_sel;
    vecs[0]  = '{1'b1, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 4'h2, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 4'h2, 1'b0, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 4'h6, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 4'h6, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 4'h6, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'h6, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 4'h3, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 4'h3, 1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 4'h3, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'h5, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1};
    @(posedge clk);
    #1;
    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst;
      a = vecs[i].a;
      a_valid = vecs[i].av;
      b = vecs[i].b;
      b_valid = vecs[i].bv;
      out_ready = vecs[i].ory;
      #2;
      chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(vecs[i].ar));
      chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(vecs[i].br));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out", i), 32'(out), 32'(vecs[i].out));
      chk($sformatf("v%0d out_sel", i), 32'(out_sel), 32'(vecs[i].sel));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
    end
    a = 4'h1;
    b = 4'h9;
    a_valid = 1'b1;
    b_valid = 1'b1;
    out_ready = 1'b1;
    exp_sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk($sformatf("fair%0d ready_onehot", i), 32'({a_ready, b_ready}), exp_sel ? 32'h1 : 32'h2);
      @(posedge clk);
      #1;
      chk($sformatf("fair%0d out_sel", i), 32'(out_sel), 32'(exp_sel));
      chk($sformatf("fair%0d out", i), 32'(out), exp_sel ? 32'h9 : 32'h1);
      exp_sel = ~exp_sel;
    end
`ifdef ARB_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("stats reset cnt_a", 32'(cnt_a), 32'h0);
    chk("stats reset cnt_b", 32'(cnt_b), 32'h0);
    b_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) chk("stats cnt_a after 10", 32'(cnt_a), 32'd10);
    end
    chk("stats cnt_a saturated", 32'(cnt_a), 32'hFF);
    chk("stats cnt_b idle", 32'(cnt_b), 32'h0);
    a_valid = 1'b0;
    b_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stats cnt_b three", 32'(cnt_b), 32'd3);
    chk("stats cnt_a holds", 32'(cnt_a), 32'hFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("stats midrun cnt_a", 32'(cnt_a), 32'h0);
    chk("stats midrun cnt_b", 32'(cnt_b), 32'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
